// File: rtl/apb_arb_pkg.sv
// Shared types and elaboration helpers for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width of the slave-select field taken from the top of the address.
    function automatic int sel_width(input int nslv);
        return (nslv > 1) ? clog2(nslv) : 1;
    endfunction

    localparam int NSLV_DEFAULT  = 4;
    localparam int SEL_W_DEFAULT = sel_width(NSLV_DEFAULT);

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: grants the first requesting bit at or after the pointer,
// wrapping modulo NREQ. Purely combinational.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        if (en_i) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = PW'((int'(ptr_i) + k) % NREQ);
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master front-end: round-robin shares one APB bus between NREQ requesters,
// decodes the slave from the top address bits and aborts stalled transfers.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NSLV    = 4,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DWIDTH-1:0]        rdata,
    output logic                     err,
    output logic [NSLV-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [AWIDTH-1:0]        PADDR,
    output logic [DWIDTH-1:0]        PWDATA,
    input  logic [NSLV*DWIDTH-1:0]   PRDATA,
    input  logic [NSLV-1:0]          PREADY
);

    localparam int SW = sel_width(NSLV);
    localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   served_q, served_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic [AWIDTH-1:0] new_addr;
    logic [DWIDTH-1:0] new_wdata;
    logic              new_we;
    logic [SW-1:0]     slv_idx;
    logic              ready_sel;
    logic [DWIDTH-1:0] prdata_sel;
    logic              to_hit;

    // served_q masks the requester that is seeing its done pulse this cycle.
    apb_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req_i (req & ~served_q),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx   = '0;
        new_addr  = '0;
        new_wdata = '0;
        new_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx   = PW'(i);
                new_addr  = req_addr[i*AWIDTH +: AWIDTH];
                new_wdata = req_wdata[i*DWIDTH +: DWIDTH];
                new_we    = req_we[i];
            end
        end
    end

    assign slv_idx = paddr_q[AWIDTH-1 -: SW];

    always_comb begin
        ready_sel  = 1'b0;
        prdata_sel = '0;
        for (int s = 0; s < NSLV; s++) begin
            if (slv_idx == SW'(s)) begin
                ready_sel  = PREADY[s];
                prdata_sel = PRDATA[s*DWIDTH +: DWIDTH];
            end
        end
    end

    assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        served_d  = '0;
        rdata_d   = '0;
        err_d     = 1'b0;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    gnt_d    = arb_gnt;
                    gidx_d   = arb_idx;
                    paddr_d  = new_addr;
                    pwrite_d = new_we;
                    if (new_we) pwdata_d = new_wdata;
                    psel_d   = NSLV'(1) << new_addr[AWIDTH-1 -: SW];
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A timeout exits exactly like a completion, flagged with err.
                if (ready_sel || to_hit) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    gnt_d     = '0;
                    done_d    = gnt_q;
                    served_d  = gnt_q;
                    err_d     = !ready_sel;
                    rdata_d   = (ready_sel && !pwrite_q) ? prdata_sel : '0;
                    ptr_d     = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            served_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            served_q  <= served_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule
